// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and the
// derivation of the iteration counter width.
package div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Counter counts WIDTH-1 down to 0; sized with one bit of headroom.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor on a WIDTH+1 bit subtractor, and either keeps the difference
// (quotient bit 1) or restores the shifted value (quotient bit 0).
// The partial remainder is always below the divisor on entry, so the
// shifted value is below twice the divisor and the borrow bit alone tells
// whether the subtraction succeeded.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; a clear borrow bit means the divisor fitted.
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, 2*WIDTH-bit dividend by
// WIDTH-bit divisor, one quotient bit per cycle.
// The first RUN cycle screens for divide-by-zero and quotient overflow;
// screened operations finish one cycle later with zero results, the rest
// run WIDTH iteration cycles and finish WIDTH+1 edges after acceptance.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands, results
// truncated toward zero, with a final range check on the signed quotient.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 dbz
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 first;
    logic                 pend_dbz;
    logic                 pend_ovf;

    // Datapath: partial remainder, dividend/quotient shift register, divisor.
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH-1:0]     dvs;

    logic                 accept;
    logic                 stepping;
    logic [WIDTH-1:0]     rem_next;
    logic                 q_bit;
    logic [WIDTH-1:0]     q_final;
    logic [2*WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]     dvs_mag;
    logic                 q_ovf;
    logic [WIDTH-1:0]     q_out;
    logic [WIDTH-1:0]     r_out;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic                 neg_q;
    logic                 neg_r;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem),
        .bit_in   (lo[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Handshake and iteration qualifiers.
    always_comb begin
        accept   = start && (state == S_IDLE || state == S_FIN);
        stepping = (state == S_RUN) && !first && !pend_dbz && !pend_ovf;
        q_final  = {lo[WIDTH-2:0], q_bit};
    end

    // Operand magnitudes fed to the unsigned core.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_mag = dividend[2*WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dvs_mag = divisor[WIDTH-1]    ? (~divisor + 1'b1)  : divisor;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
`endif
    end

    // Final result formatting: sign restoration and signed range check.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_ovf = neg_q ? (q_final > HALF) : (q_final > (HALF - 1'b1));
        q_out = neg_q ? (~q_final + 1'b1) : q_final;
        r_out = neg_r ? (~rem_next + 1'b1) : rem_next;
`else
        q_ovf = 1'b0;
        q_out = q_final;
        r_out = rem_next;
`endif
    end

    // Datapath registers: load magnitudes on acceptance, shift once per iteration.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem <= dvd_mag[2*WIDTH-1:WIDTH];
            lo  <= dvd_mag[WIDTH-1:0];
            dvs <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[2*WIDTH-1];
`endif
        end else if (stepping) begin
            rem <= rem_next;
            lo  <= q_final;
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            first     <= 1'b0;
            pend_dbz  <= 1'b0;
            pend_ovf  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if (accept) begin
            state    <= S_RUN;
            cnt      <= CNT_W'(WIDTH - 1);
            first    <= 1'b1;
            pend_dbz <= 1'b0;
            pend_ovf <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (first) begin
                        first    <= 1'b0;
                        pend_dbz <= (dvs == '0);
                        pend_ovf <= (dvs != '0) && (rem >= dvs);
                    end else if (pend_dbz || pend_ovf) begin
                        state     <= S_FIN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                        dbz       <= pend_dbz;
                        ovf       <= pend_ovf;
                    end else if (cnt == '0) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (q_ovf) begin
                            ovf       <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                        end else begin
                            quotient  <= q_out;
                            remainder <= r_out;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider.
// Stimulus pushes the expected result and completion cycle of every accepted
// operation; a monitor pops and compares on each done pulse.
// Follows SEQ_DIVIDER_SIGNED_EN when the bundle is built with it.
module tb_seq_divider;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2*W-1:0]   dividend = '0;
    logic [W-1:0]     divisor = '0;
    logic             busy;
    logic             done;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             ovf;
    logic             dbz;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           ovf;
        logic           dbz;
        int             due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain arithmetic on the operand values. e0 is the cycle
    // number after the accepting edge.
    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b, input int e0);
        exp_t   e;
        longint x;
        longint y;
        longint qq;
        longint rr;
        e.a = a; e.b = b; e.q = '0; e.r = '0; e.ovf = 1'b0; e.dbz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        x = longint'($signed(a));
        y = longint'($signed(b));
`else
        x = longint'(a);
        y = longint'(b);
`endif
        if (y == 0) begin
            e.dbz = 1'b1;
            e.due = e0 + 2;
        end else if (((x < 0) ? -x : x) / ((y < 0) ? -y : y) >= (longint'(1) << W)) begin
            e.ovf = 1'b1;
            e.due = e0 + 2;
        end else begin
            qq = x / y;
            rr = x % y;
            e.due = e0 + W + 1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (qq > (longint'(1) << (W-1)) - 1 || qq < -(longint'(1) << (W-1))) begin
                e.ovf = 1'b1;
            end else begin
                e.q = qq[W-1:0];
                e.r = rr[W-1:0];
            end
`else
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
`endif
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1, expected no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result{q,r,ovf,dbz}", {22'd0, quotient, remainder, ovf, dbz},
                      {22'd0, e.q, e.r, e.ovf, e.dbz});
                check("done_cycle", cyc, e.due);
                check("busy_in_fin", {31'd0, busy}, 32'd0);
`ifndef SEQ_DIVIDER_SIGNED_EN
                if (!e.ovf && !e.dbz) begin
                    check("invariant", quotient * e.b + remainder, {24'd0, e.a});
                end
`endif
            end
        end
    end

    // Present operands and start at a falling edge; returns the expectation.
    task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit hold, output exp_t e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e = model(a, b, cyc + 1);
        sb.push_back(e);
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending ops, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        exp_t e2;
        logic [W-1:0]   rb;
        logic [2*W-1:0] ra;

        // Reset state
        #12;
        check("reset_outputs", {26'd0, busy, done, ovf, dbz, quotient != 0, remainder != 0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors: normal, overflow, divide-by-zero, signed cases
        issue(8'h64, 4'd7, 1'b0, e); wait_idle();
        issue(8'h70, 4'd7, 1'b0, e); wait_idle();
        issue(8'h55, 4'd0, 1'b0, e); wait_idle();
        issue(8'hCE, 4'd7, 1'b0, e); wait_idle();
        issue(8'h9C, 4'd7, 1'b0, e); wait_idle();
        issue(8'h6F, 4'd7, 1'b0, e); wait_idle();
        issue(8'h00, 4'd1, 1'b0, e); wait_idle();
        issue(8'hFF, 4'hF, 1'b0, e); wait_idle();

        // Start pulsed mid-run with other operands must be ignored
        issue(8'h64, 4'd7, 1'b0, e);
        @(negedge clk);
        dividend = 8'h30; divisor = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start held through FIN: back-to-back operations
        issue(8'h64, 4'd7, 1'b1, e);
        dividend = 8'h2B; divisor = 4'd6;
        e2 = model(8'h2B, 4'd6, e.due + 1);
        sb.push_back(e2);
        for (int n = 0; n < 50 && cyc < e.due + 1; n++) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset during iteration 2: immediate clear, no done, clean restart
        issue(8'h64, 4'd7, 1'b0, e);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_outputs", {26'd0, busy, done, ovf, dbz, quotient != 0, remainder != 0}, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        issue(8'h2B, 4'd6, 1'b0, e); wait_idle();

        // Randomized operations, biased toward non-overflowing dividends
        for (int i = 0; i < 40; i++) begin
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0 && rb != 0)
                ra = 8'($urandom_range(0, int'(rb) * 16 - 1));
            else
                ra = 8'($urandom_range(0, 255));
            issue(ra, rb, 1'b0, e);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
